// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between two requesters.
// A grant is held until the holder's last word or the burst limit.
module fifo_wr_arbiter #(
  parameter int data_size = 8,
  parameter int burst_max = 4
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 req0_valid,
  input  logic [data_size-1:0] req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [data_size-1:0] req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  input  logic                 full,
  output logic                 wr_clken,
  output logic [data_size-1:0] data_in,
  output logic                 grant_id,
  output logic                 busy,
  output logic [15:0]          wr_count
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam int              CW        = $clog2(burst_max + 1);
  localparam logic [CW-1:0]   BEAT_LAST = CW'(burst_max - 1);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_id_q, grant_id_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]    wr_count_q, wr_count_d;

  logic hold_valid;
  logic hold_last;
  logic beat;
  logic release_grant;

  assign hold_valid    = grant_id_q ? req1_valid : req0_valid;
  assign hold_last     = grant_id_q ? req1_last  : req0_last;
  assign beat          = (state_q == LOCKED) && hold_valid && !full;
  assign release_grant = beat && (hold_last || (beat_cnt_q == BEAT_LAST));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      beat_cnt_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    wr_count_d   = wr_count_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On contention the requester that did not hold the last grant wins.
          grant_id_d = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          wr_count_d = wr_count_q + 16'd1;
        end
        if (release_grant) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == LOCKED) && !full) begin
      req0_ready = !grant_id_q;
      req1_ready = grant_id_q;
    end
    wr_clken = beat;
    data_in  = grant_id_q ? req1_data : req0_data;
    busy     = (state_q == LOCKED);
    grant_id = grant_id_q;
    wr_count = wr_count_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int BURST = 4;

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       full = 1'b0;

  logic       req0_ready, req1_ready, wr_clken, grant_id, busy;
  logic [7:0] data_in;
  logic [15:0] wr_count;

  logic       b1_req0_ready, b1_req1_ready, b1_wr_clken, b1_grant_id, b1_busy;
  logic [7:0] b1_data_in;
  logic [15:0] b1_wr_count;

  int errors = 0;
  int checks = 0;

  // Model state: who owns the port (-1 none), words taken this grant,
  // previous owner, reported grant id, and words written.
  int          m_owner;
  int          m_taken;
  int          m_prev;
  int          m_gid;
  logic [15:0] m_count;

  fifo_wr_arbiter #(.data_size(8), .burst_max(BURST)) u_dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .full(full), .wr_clken(wr_clken), .data_in(data_in),
    .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.data_size(8), .burst_max(1)) u_dut_b1 (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(b1_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(b1_req1_ready),
    .full(full), .wr_clken(b1_wr_clken), .data_in(b1_data_in),
    .grant_id(b1_grant_id), .busy(b1_busy), .wr_count(b1_wr_count)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_last  = 1'b0; req1_last  = 1'b0;
    req0_data  = '0;   req1_data  = '0;
    full       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    wr_rst = 1'b1;
    step();
    step();
    wr_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    wr_rst = 1'b1;
    #2;
    checks++; if (wr_clken !== 1'b0) begin errors++; $display("FAIL reset_wr_clken: got %b want 0", wr_clken); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b want 0", grant_id); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count: got %h want 0000", wr_count); end
    step();
    wr_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (busy !== 1'b0 || wr_clken !== 1'b0) begin errors++; $display("FAIL reset_stay_idle: busy=%b wr_clken=%b want 0 0", busy, wr_clken); end
      step();
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_d;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hA1; req0_last = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0 || wr_clken !== 1'b0) begin errors++; $display("FAIL single_idle_cycle: ready=%b wr_clken=%b want 0 0", req0_ready, wr_clken); end
    step();
    for (int i = 0; i < 3; i++) begin
      exp_d     = 8'hA1 + 8'(i);
      req0_data = exp_d;
      req0_last = (i == 2);
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready[%0d]: got %b want 1", i, req0_ready); end
      checks++; if (wr_clken !== 1'b1) begin errors++; $display("FAIL single_wr_clken[%0d]: got %b want 1", i, wr_clken); end
      checks++; if (data_in !== exp_d) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, data_in, exp_d); end
      step();
    end
    req0_valid = 1'b0; req0_last = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL single_wr_count: got %0d want 3", wr_count); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      int         holder;
      logic       beat_exp;
      logic [7:0] exp_d;
      holder    = ((k / 5) == 1) ? 1 : 0;
      beat_exp  = (k % 5) != 0;
      req0_data = 8'h10 + 8'(k);
      req1_data = 8'h40 + 8'(k);
      exp_d     = (holder == 1) ? 8'h40 + 8'(k) : 8'h10 + 8'(k);
      #1;
      checks++; if (wr_clken !== beat_exp) begin errors++; $display("FAIL rr_wr_clken[%0d]: got %b want %b", k, wr_clken, beat_exp); end
      checks++; if (req0_ready !== (beat_exp && holder == 0)) begin errors++; $display("FAIL rr_req0_ready[%0d]: got %b", k, req0_ready); end
      checks++; if (req1_ready !== (beat_exp && holder == 1)) begin errors++; $display("FAIL rr_req1_ready[%0d]: got %b", k, req1_ready); end
      if (beat_exp) begin
        checks++; if (grant_id !== 1'(holder)) begin errors++; $display("FAIL rr_grant_id[%0d]: got %b want %0d", k, grant_id, holder); end
        checks++; if (data_in !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, data_in, exp_d); end
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (wr_count !== 16'd12) begin errors++; $display("FAIL rr_wr_count: got %0d want 12", wr_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_full_stall();
    bit fulls [7] = '{0, 0, 0, 1, 1, 0, 0};
    bit wens  [7] = '{0, 1, 1, 0, 0, 1, 1};
    int words = 0;
    do_reset();
    req1_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      full      = fulls[c];
      req1_data = 8'hB0 + 8'(words);
      #1;
      checks++; if (wr_clken !== wens[c]) begin errors++; $display("FAIL stall_wr_clken[%0d]: got %b want %b", c, wr_clken, wens[c]); end
      checks++; if (req1_ready !== (c > 0 && !fulls[c])) begin errors++; $display("FAIL stall_req1_ready[%0d]: got %b", c, req1_ready); end
      if (wens[c]) begin
        checks++; if (data_in !== 8'hB0 + 8'(words)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", c, data_in, 8'hB0 + 8'(words)); end
        words++;
      end
      step();
    end
    req1_valid = 1'b0; full = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_after: got %b want 0", busy); end
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL stall_wr_count: got %0d want 4", wr_count); end
  endtask

  task automatic test_holder_idle();
    bit v0   [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    bit wens [10] = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 1};
    do_reset();
    req0_data = 8'hC5; req1_data = 8'h5C; req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic busy_exp;
      busy_exp   = (c >= 1 && c <= 7) || c == 9;
      req0_valid = v0[c];
      #1;
      checks++; if (wr_clken !== wens[c]) begin errors++; $display("FAIL hidle_wr_clken[%0d]: got %b want %b", c, wr_clken, wens[c]); end
      checks++; if (req1_ready !== (c == 9)) begin errors++; $display("FAIL hidle_req1_ready[%0d]: got %b", c, req1_ready); end
      checks++; if (grant_id !== (c == 9)) begin errors++; $display("FAIL hidle_grant_id[%0d]: got %b", c, grant_id); end
      checks++; if (busy !== busy_exp) begin errors++; $display("FAIL hidle_busy[%0d]: got %b want %b", c, busy, busy_exp); end
      if (wens[c]) begin
        checks++; if (data_in !== ((c == 9) ? 8'h5C : 8'hC5)) begin errors++; $display("FAIL hidle_data[%0d]: got %h", c, data_in); end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // A one-word req0 packet first, so the previous grant belongs to req0.
    req0_valid = 1'b1; req0_last = 1'b1; req0_data = 8'h11;
    step();
    #1;
    checks++; if (wr_clken !== 1'b1) begin errors++; $display("FAIL rmb_req0_word: got %b want 1", wr_clken); end
    step();
    req0_valid = 1'b0; req0_last = 1'b0; req1_valid = 1'b1; req1_data = 8'h77;
    step();
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++; if (wr_clken !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL rmb_beat[%0d]: wr_clken=%b grant_id=%b want 1 1", b, wr_clken, grant_id); end
      step();
    end
    wr_rst = 1'b1;
    #1;
    checks++; if (wr_clken !== 1'b0) begin errors++; $display("FAIL rmb_wr_clken: got %b want 0", wr_clken); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rmb_req1_ready: got %b want 0", req1_ready); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rmb_wr_count: got %0d want 0", wr_count); end
    checks++; if (busy !== 1'b0 || grant_id !== 1'b0) begin errors++; $display("FAIL rmb_state: busy=%b grant_id=%b want 0 0", busy, grant_id); end
    req0_valid = 1'b1;
    step();
    wr_rst = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0 || wr_clken !== 1'b0) begin errors++; $display("FAIL rmb_idle: ready=%b wr_clken=%b want 0 0", req0_ready, wr_clken); end
    step();
    checks++; if (grant_id !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmb_rearb: grant_id=%b r0=%b r1=%b want 0 1 0", grant_id, req0_ready, req1_ready); end
    clear_inputs();
  endtask

  task automatic test_burst_one();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h0A; req1_data = 8'h1B;
    for (int c = 0; c < 6; c++) begin
      logic beat_exp;
      int   holder;
      beat_exp = (c % 2) == 1;
      holder   = (c / 2) % 2;
      #1;
      checks++; if (b1_wr_clken !== beat_exp) begin errors++; $display("FAIL b1_wr_clken[%0d]: got %b want %b", c, b1_wr_clken, beat_exp); end
      checks++; if (b1_busy !== beat_exp) begin errors++; $display("FAIL b1_busy[%0d]: got %b want %b", c, b1_busy, beat_exp); end
      if (beat_exp) begin
        checks++; if (b1_grant_id !== 1'(holder)) begin errors++; $display("FAIL b1_grant_id[%0d]: got %b want %0d", c, b1_grant_id, holder); end
        checks++; if (b1_data_in !== ((holder == 1) ? 8'h1B : 8'h0A)) begin errors++; $display("FAIL b1_data[%0d]: got %h", c, b1_data_in); end
      end
      step();
    end
    clear_inputs();
    #1;
    checks++; if (b1_wr_count !== 16'd3) begin errors++; $display("FAIL b1_wr_count: got %0d want 3", b1_wr_count); end
  endtask

  task automatic test_random();
    int   seq0 = 0;
    int   seq1 = 0;
    logic e_r0, e_r1, e_wen, e_busy, e_last;
    logic [7:0] e_data;
    do_reset();
    m_owner = -1; m_taken = 0; m_prev = 1; m_gid = 0; m_count = '0;
    for (int n = 0; n < 500; n++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_last  = ($urandom_range(0, 3) == 0);
      req1_last  = ($urandom_range(0, 3) == 0);
      full       = ($urandom_range(0, 4) == 0);
      req0_data  = {1'b0, 7'(seq0)};
      req1_data  = {1'b1, 7'(seq1)};
      #1;
      e_busy = (m_owner >= 0);
      e_r0   = (m_owner == 0) && !full;
      e_r1   = (m_owner == 1) && !full;
      e_wen  = (e_r0 && req0_valid) || (e_r1 && req1_valid);
      e_data = (m_owner == 1) ? req1_data : req0_data;
      e_last = (m_owner == 1) ? req1_last : req0_last;
      checks++; if (req0_ready !== e_r0) begin errors++; $display("FAIL rand_req0_ready[%0d]: got %b want %b", n, req0_ready, e_r0); end
      checks++; if (req1_ready !== e_r1) begin errors++; $display("FAIL rand_req1_ready[%0d]: got %b want %b", n, req1_ready, e_r1); end
      checks++; if (wr_clken !== e_wen) begin errors++; $display("FAIL rand_wr_clken[%0d]: got %b want %b", n, wr_clken, e_wen); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, e_busy); end
      checks++; if (grant_id !== 1'(m_gid)) begin errors++; $display("FAIL rand_grant_id[%0d]: got %b want %0d", n, grant_id, m_gid); end
      checks++; if (wr_count !== m_count) begin errors++; $display("FAIL rand_wr_count[%0d]: got %0d want %0d", n, wr_count, m_count); end
      if (e_wen) begin
        checks++; if (data_in !== e_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, data_in, e_data); end
      end
      // Advance the model by one clock.
      if (m_owner < 0) begin
        if (req0_valid || req1_valid) begin
          m_owner = (req0_valid && req1_valid) ? 1 - m_prev : (req0_valid ? 0 : 1);
          m_gid   = m_owner;
          m_taken = 0;
        end
      end else if (e_wen) begin
        if (m_owner == 0) seq0++; else seq1++;
        m_taken++;
        m_count++;
        if (e_last || m_taken == BURST) begin
          m_prev  = m_owner;
          m_owner = -1;
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_holder_idle();
    test_reset_mid_burst();
    test_burst_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the FIFO memory write port (`wr_clk` domain). It shares the single write port (`wr_clken`, data, `full`) between two requesters using round-robin arbitration with burst locking. A granted requester keeps the port until it marks its last word or reaches a configurable burst limit. It also keeps a running count of words written, for debug.

## Interface

Parameters:
- `data_size`, 8: width of the data word; must match the memory data width.
- `burst_max`, 4: maximum number of words per grant; legal range 1–255.

Ports:
- `wr_clk`  in  1  write clock; all state changes on its rising edge.
- `wr_rst`  in  1  reset, asynchronous and active-high.
- `req0_valid`, `req1_valid`  in  1 each  requester has a word presented.
- `req0_data`, `req1_data`  in  `data_size` each  requester write data.
- `req0_last`, `req1_last`  in  1 each  the presented word ends this requester's packet.
- `req0_ready`, `req1_ready`  out  1 each  the word is accepted this cycle when valid is also high.
- `full`  in  1  FIFO full flag, already synchronised into `wr_clk`.
- `wr_clken`  out  1  write enable to the memory.
- `data_in`  out  `data_size`  write data to the memory.
- `grant_id`  out  1  index of the current or most recent grant holder.
- `busy`  out  1  high while a grant is held (state LOCKED).
- `wr_count`  out  16  total words written; wraps modulo 2^16.

## Operation

- FSM states: IDLE and LOCKED. Reset state is IDLE.
- Registers:
  - `last_grant`: reset value 1, so req0 wins the first arbitration.
  - `grant_id`: reset value 0.
  - `beat_cnt`: width $clog2(burst_max+1), reset value 0.
  - `wr_count`: reset value 0.
- IDLE:
  - Both ready outputs are 0 and `wr_clken` is 0.
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester ≠ `last_grant` wins.
  - On the clock edge with a winner: `grant_id` ← winner, `beat_cnt` ← 0, state → LOCKED.
  - If no valid is high, stay in IDLE.
- LOCKED:
  - `reqN_ready` = (N == `grant_id`) && !`full`. The non-holder's ready is 0.
  - A beat occurs when `reqN_valid` && `reqN_ready` for the holder.
  - `wr_clken` = beat, combinational. `data_in` = the holder's data, combinational.
  - On each beat: `beat_cnt` +1, `wr_count` +1.
  - The grant is released on a beat where the holder's last = 1, or where `beat_cnt` == `burst_max`−1.
  - On release: state → IDLE, `last_grant` ← `grant_id`, `beat_cnt` ← 0.
  - If the holder drops valid mid-burst, the grant is kept; the other requester waits.
  - `full` high stalls the transfer: no beat occurs and no counter changes.
- `busy` = (state == LOCKED).
- Because the memory's write is gated by `full` and `wr_clken` is already gated by `full`, no word is accepted without being written.
- Reset asserted at any time, including mid-burst, forces IDLE and all registers to their reset values immediately. Any partial burst is abandoned and nothing more is written.

## Timing

- Arbitration latency: 1 cycle from the valid rising in IDLE to the first ready.
- In LOCKED there is zero latency from valid&&ready to `wr_clken`/`data_in`, in the same cycle.
- One IDLE cycle separates consecutive grants, including back-to-back grants to the same requester.
- Throughput: up to `burst_max` words per `burst_max`+1 cycles.
- `burst_max` = 1: every beat releases, so requesters alternate one word each.
- `wr_count` overflow: 0xFFFF + 1 → 0x0000, with no flag.

## Test plan

- **Reset:** hold `wr_rst`=1 → `wr_clken`=0, both ready=0, `busy`=0, `grant_id`=0, `wr_count`=0. Deassert with no valids → remains IDLE.
- **Single packet:** req0 presents 0xA1, 0xA2, 0xA3 with last on 0xA3; `full`=0; `burst_max`=4 → IDLE cycle, then ready high for 3 cycles. `data_in` is 0xA1, 0xA2, 0xA3 with `wr_clken`=1. Next cycle `busy`=0 and `wr_count`=3.
- **Round robin:** both requesters valid continuously, last never set, `burst_max`=4 → grants alternate req0, req1, req0. Each grant writes exactly 4 words, with 1 idle cycle between grants. After 3 grants `wr_count`=12.
- **Full stall:** during a req1 burst, `full`=1 for 2 cycles after its 2nd beat → ready and `wr_clken` are 0 for those cycles and `beat_cnt` holds at 2. When `full` drops, the remaining 2 words are written with no loss or duplicate.
- **Holder idle:** req0 locked, drops valid for 3 cycles mid-burst while req1 is valid → `req1_ready` stays 0 and `grant_id` stays 0. req0 resumes and finishes its burst; then req1 is granted.
- **Reset mid-burst:** assert `wr_rst` after the 2nd beat of a 4-word burst → `wr_clken` and ready go 0 immediately, and `wr_count`=0. After release, req0 wins the next arbitration.
